// File: rtl/axisr_host_src_arbiter_pkg.sv
// Shared widths and types for the host-source stream arbiter.
//   AXI_DATA_BITS : default tdata width of a host stream
//   PID_BITS      : default tid (PID) width
//   N_STRM_AXI    : default number of user host-source streams
//   arb_state_t   : arbiter FSM state (IDLE / LOCKED)
package axisr_host_src_arbiter_pkg;

  localparam int AXI_DATA_BITS = 512;
  localparam int PID_BITS      = 6;
  localparam int N_STRM_AXI    = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axisr_host_src_arbiter_if.sv
// AXI4-Stream (with tid) bundle carrying N lanes side by side.
// Lane i occupies tdata[i*DATA_BITS +: DATA_BITS], tkeep[i*DATA_BITS/8 +: DATA_BITS/8],
// tid[i*ID_BITS +: ID_BITS], and bit i of tlast/tvalid/tready.
//   master : drives tdata/tkeep/tid/tlast/tvalid, receives tready
//   slave  : receives tdata/tkeep/tid/tlast/tvalid, drives tready
interface axisr_host_src_arbiter_if
  import axisr_host_src_arbiter_pkg::*;
#(
  parameter int N         = 1,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int ID_BITS   = PID_BITS
);
  logic [N*DATA_BITS-1:0]     tdata;
  logic [N*(DATA_BITS/8)-1:0] tkeep;
  logic [N*ID_BITS-1:0]       tid;
  logic [N-1:0]               tlast;
  logic [N-1:0]               tvalid;
  logic [N-1:0]               tready;

  modport master (output tdata, tkeep, tid, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tid, tlast, tvalid, output tready);
endinterface

// File: rtl/axisr_host_src_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   i_req     : request per input
//   i_ptr     : index that has highest priority this cycle
//   o_gnt_idx : first requesting index at or after i_ptr (mod N_IN)
//   o_gnt_vld : at least one request present
module axisr_host_src_arbiter_rr_pick #(
  parameter int N_IN  = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_IN-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_vld
);

  logic [IDX_W-1:0] w_idx;

  // Walk the ring starting at i_ptr; explicit wrap keeps non-power-of-2 N_IN legal.
  always_comb begin
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_idx     = i_ptr;
    for (int k = 0; k < N_IN; k++) begin
      if (!o_gnt_vld && i_req[w_idx]) begin
        o_gnt_idx = w_idx;
        o_gnt_vld = 1'b1;
      end
      w_idx = (w_idx == IDX_W'(N_IN - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axisr_host_src_arbiter.sv
// Packet-atomic round-robin merge of N_IN host source streams into one
// registered host source stream. A winning input owns the output until its
// tlast beat is accepted; packets are never interleaved.
//   aclk    : clock (rising edge)
//   aresetn : asynchronous active-low reset
//   s       : N_IN input lanes (slave side)
//   m       : single merged output lane (master side, registered)
//   busy    : high while a packet is locked onto the output
module axisr_host_src_arbiter
  import axisr_host_src_arbiter_pkg::*;
#(
  parameter int N_IN      = N_STRM_AXI,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int ID_BITS   = PID_BITS
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axisr_host_src_arbiter_if.slave  s,
  axisr_host_src_arbiter_if.master m,
  output logic                     busy
);

  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int KEEP_W = DATA_BITS / 8;

  arb_state_t           r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_lock_idx;
  logic [DATA_BITS-1:0] r_tdata;
  logic [KEEP_W-1:0]    r_tkeep;
  logic [ID_BITS-1:0]   r_tid;
  logic                 r_tlast;
  logic                 r_tvalid;

  logic [IDX_W-1:0]     w_gnt_idx;
  logic                 w_gnt_vld;
  logic [IDX_W-1:0]     w_sel;
  logic                 w_sel_vld;
  logic                 w_out_free;
  logic                 w_accept;
  logic [N_IN-1:0]      w_tready;
  logic                 w_lane_last;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_IN - 1)) ? '0 : idx + 1'b1;
  endfunction

  axisr_host_src_arbiter_rr_pick #(
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req     (s.tvalid),
    .i_ptr     (r_rr_ptr),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  // Gating with aresetn keeps every s_tready low while reset is held.
  assign w_out_free = aresetn & (~r_tvalid | m.tready[0]);

  // In LOCKED the owner keeps its ready even with tvalid low, so ready never
  // depends on the owner's own tvalid.
  assign w_sel     = (r_state == LOCKED) ? r_lock_idx : w_gnt_idx;
  assign w_sel_vld = (r_state == LOCKED) ? 1'b1 : w_gnt_vld;

  always_comb begin
    w_tready = '0;
    if (w_sel_vld) w_tready[w_sel] = w_out_free;
  end

  assign w_accept    = w_sel_vld & w_out_free & s.tvalid[w_sel];
  assign w_lane_last = s.tlast[w_sel];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
      r_tdata    <= '0;
      r_tkeep    <= '0;
      r_tid      <= '0;
      r_tlast    <= 1'b0;
      r_tvalid   <= 1'b0;
    end else begin
      // Output register: load wins over drain, so a beat can replace the
      // one leaving in the same cycle.
      if (w_accept) begin
        r_tdata  <= s.tdata[int'(w_sel)*DATA_BITS +: DATA_BITS];
        r_tkeep  <= s.tkeep[int'(w_sel)*KEEP_W +: KEEP_W];
        r_tid    <= s.tid[int'(w_sel)*ID_BITS +: ID_BITS];
        r_tlast  <= w_lane_last;
        r_tvalid <= 1'b1;
      end else if (m.tready[0]) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_lane_last) begin
              r_rr_ptr <= f_next(w_sel);
            end else begin
              r_state    <= LOCKED;
              r_lock_idx <= w_sel;
            end
          end
        end
        LOCKED: begin
          if (w_accept && w_lane_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= f_next(r_lock_idx);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s.tready = w_tready;
  assign m.tdata  = r_tdata;
  assign m.tkeep  = r_tkeep;
  assign m.tid    = r_tid;
  assign m.tlast  = r_tlast;
  assign m.tvalid = r_tvalid;
  assign busy     = (r_state == LOCKED);

endmodule

// File: tb/tb_axisr_host_src_arbiter.sv
// Directed bench for axisr_host_src_arbiter: a 4-input and a 3-input instance
// sharing clock and reset. Inputs change 1 time unit after the rising edge;
// registered outputs are sampled 1 unit after the edge, combinational
// s_tready 1 unit after the inputs change.
module tb_axisr_host_src_arbiter;

  logic aclk;
  logic aresetn;
  logic busy4;
  logic busy3;
  int   checks;
  int   errors;

  axisr_host_src_arbiter_if #(.N(4), .DATA_BITS(16), .ID_BITS(4)) s4 ();
  axisr_host_src_arbiter_if #(.N(1), .DATA_BITS(16), .ID_BITS(4)) m4 ();
  axisr_host_src_arbiter_if #(.N(3), .DATA_BITS(16), .ID_BITS(4)) s3 ();
  axisr_host_src_arbiter_if #(.N(1), .DATA_BITS(16), .ID_BITS(4)) m3 ();

  axisr_host_src_arbiter #(.N_IN(4), .DATA_BITS(16), .ID_BITS(4)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .s(s4), .m(m4), .busy(busy4)
  );

  axisr_host_src_arbiter #(.N_IN(3), .DATA_BITS(16), .ID_BITS(4)) dut3 (
    .aclk(aclk), .aresetn(aresetn), .s(s3), .m(m3), .busy(busy3)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  // Beat payload {lane, packet, beat}, readable in hex.
  function automatic logic [15:0] dat(input int lane, input int pkt, input int beat);
    return {4'(lane), 4'(pkt), 8'(beat)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv4(input int i, input logic v, input logic [15:0] d, input logic l);
    s4.tvalid[i]          = v;
    s4.tdata[i*16 +: 16]  = d;
    s4.tlast[i]           = l;
    s4.tkeep[i*2 +: 2]    = 2'b11;
    s4.tid[i*4 +: 4]      = 4'(i + 5);
  endtask

  task automatic drv3(input int i, input logic v, input logic [15:0] d, input logic l);
    s3.tvalid[i]          = v;
    s3.tdata[i*16 +: 16]  = d;
    s3.tlast[i]           = l;
    s3.tkeep[i*2 +: 2]    = 2'b11;
    s3.tid[i*4 +: 4]      = 4'(i + 5);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
  endtask

  initial begin
    int bt[4];
    int pk[4];
    logic [3:0] rdy;

    checks = 0;
    errors = 0;
    aresetn = 1'b0;
    s4.tdata = '0; s4.tkeep = '0; s4.tid = '0; s4.tlast = '0; s4.tvalid = '0;
    s3.tdata = '0; s3.tkeep = '0; s3.tid = '0; s3.tlast = '0; s3.tvalid = '0;
    m4.tready = 1'b1;
    m3.tready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_m4_tvalid", 32'(m4.tvalid), 32'd0);
    chk("rst_m4_tlast",  32'(m4.tlast),  32'd0);
    chk("rst_m4_tdata",  32'(m4.tdata),  32'd0);
    chk("rst_s4_tready", 32'(s4.tready), 32'd0);
    chk("rst_busy4",     32'(busy4),     32'd0);
    chk("rst_m3_tvalid", 32'(m3.tvalid), 32'd0);
    chk("rst_s3_tready", 32'(s3.tready), 32'd0);
    aresetn = 1'b1;

    // Single input, three back-to-back 4-beat packets
    for (int k = 0; k < 12; k++) begin
      drv4(0, 1'b1, dat(0, k / 4, k % 4), (k % 4) == 3);
      #1;
      chk("t1_rdy", 32'(s4.tready), 32'b0001);
      if (k == 0) chk("t1_latency", 32'(m4.tvalid), 32'd0);
      tick();
      chk("t1_vld",  32'(m4.tvalid), 32'd1);
      chk("t1_data", 32'(m4.tdata), 32'(dat(0, k / 4, k % 4)));
      chk("t1_last", 32'(m4.tlast), 32'((k % 4) == 3));
      chk("t1_tid",  32'(m4.tid),   32'd5);
    end
    drv4(0, 1'b0, 16'h0, 1'b0);
    tick();
    chk("t1_drain", 32'(m4.tvalid), 32'd0);

    // Fair rotation, all four inputs continuously valid, 2-beat packets
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bt[i] = 0;
      pk[i] = 0;
    end
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 4; i++) drv4(i, 1'b1, dat(i, pk[i], bt[i]), bt[i] == 1);
      #1;
      rdy = s4.tready;
      chk("t2_rdy", 32'(rdy), 32'(4'b0001 << ((c / 2) % 4)));
      tick();
      chk("t2_vld",  32'(m4.tvalid), 32'd1);
      chk("t2_data", 32'(m4.tdata), 32'(dat((c / 2) % 4, c / 8, c % 2)));
      chk("t2_busy", 32'(busy4), 32'((c % 2) == 0));
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) begin
          if (bt[i] == 1) begin
            bt[i] = 0;
            pk[i]++;
          end else begin
            bt[i]++;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) drv4(i, 1'b0, 16'h0, 1'b0);
    tick();
    chk("t2_drain", 32'(m4.tvalid), 32'd0);

    // Lock under source stall: input 2 owns the output, input 0 waits
    drv4(2, 1'b1, dat(2, 0, 0), 1'b0);
    #1;
    chk("t3_rdy_first", 32'(s4.tready), 32'b0100);
    tick();
    chk("t3_b0", 32'(m4.tdata), 32'(dat(2, 0, 0)));
    chk("t3_busy_b0", 32'(busy4), 32'd1);
    drv4(2, 1'b0, dat(2, 0, 1), 1'b0);
    drv4(0, 1'b1, dat(0, 0, 0), 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_stall_rdy", 32'(s4.tready), 32'b0100);
      tick();
      chk("t3_stall_busy", 32'(busy4), 32'd1);
      chk("t3_stall_vld", 32'(m4.tvalid), 32'd0);
    end
    drv4(2, 1'b1, dat(2, 0, 1), 1'b0);
    #1;
    chk("t3_rdy_b1", 32'(s4.tready), 32'b0100);
    tick();
    chk("t3_b1", 32'(m4.tdata), 32'(dat(2, 0, 1)));
    drv4(2, 1'b1, dat(2, 0, 2), 1'b1);
    tick();
    chk("t3_b2", 32'(m4.tdata), 32'(dat(2, 0, 2)));
    chk("t3_b2_last", 32'(m4.tlast), 32'd1);
    chk("t3_busy_end", 32'(busy4), 32'd0);
    drv4(2, 1'b0, 16'h0, 1'b0);
    #1;
    chk("t3_rdy_in0", 32'(s4.tready), 32'b0001);
    tick();
    chk("t3_in0", 32'(m4.tdata), 32'(dat(0, 0, 0)));
    chk("t3_in0_tid", 32'(m4.tid), 32'd5);
    drv4(0, 1'b0, 16'h0, 1'b0);
    tick();
    chk("t3_drain", 32'(m4.tvalid), 32'd0);

    // Output backpressure on a 4-beat packet from input 1, m_tready 1,0,0,1
    drv4(1, 1'b1, dat(1, 0, 0), 1'b0);
    m4.tready = 1'b1;
    #1;
    chk("t4_rdy0", 32'(s4.tready), 32'b0010);
    tick();
    chk("t4_b0", 32'(m4.tdata), 32'(dat(1, 0, 0)));
    drv4(1, 1'b1, dat(1, 0, 1), 1'b0);
    m4.tready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t4_stall_rdy", 32'(s4.tready), 32'b0000);
      tick();
      chk("t4_hold_vld",  32'(m4.tvalid), 32'd1);
      chk("t4_hold_data", 32'(m4.tdata), 32'(dat(1, 0, 0)));
      chk("t4_hold_last", 32'(m4.tlast), 32'd0);
    end
    m4.tready = 1'b1;
    #1;
    chk("t4_rdy_resume", 32'(s4.tready), 32'b0010);
    tick();
    chk("t4_b1", 32'(m4.tdata), 32'(dat(1, 0, 1)));
    chk("t4_b1_vld", 32'(m4.tvalid), 32'd1);
    drv4(1, 1'b1, dat(1, 0, 2), 1'b0);
    tick();
    chk("t4_b2", 32'(m4.tdata), 32'(dat(1, 0, 2)));
    drv4(1, 1'b1, dat(1, 0, 3), 1'b1);
    tick();
    chk("t4_b3", 32'(m4.tdata), 32'(dat(1, 0, 3)));
    chk("t4_b3_last", 32'(m4.tlast), 32'd1);
    chk("t4_busy_end", 32'(busy4), 32'd0);
    drv4(1, 1'b0, 16'h0, 1'b0);
    tick();
    chk("t4_drain", 32'(m4.tvalid), 32'd0);

    // Wrap with N_IN=3: a packet from input 1 leaves rr_ptr at 2
    drv3(1, 1'b1, dat(1, 0, 0), 1'b1);
    #1;
    chk("t5_rdy_in1", 32'(s3.tready), 32'b010);
    tick();
    chk("t5_in1", 32'(m3.tdata), 32'(dat(1, 0, 0)));
    drv3(1, 1'b0, 16'h0, 1'b0);
    drv3(0, 1'b1, dat(0, 0, 0), 1'b1);
    drv3(2, 1'b1, dat(2, 0, 0), 1'b1);
    #1;
    chk("t5_rdy_in2", 32'(s3.tready), 32'b100);
    tick();
    chk("t5_in2", 32'(m3.tdata), 32'(dat(2, 0, 0)));
    chk("t5_in2_tid", 32'(m3.tid), 32'd7);
    drv3(2, 1'b1, dat(2, 1, 0), 1'b1);
    #1;
    chk("t5_rdy_wrap_in0", 32'(s3.tready), 32'b001);
    tick();
    chk("t5_in0", 32'(m3.tdata), 32'(dat(0, 0, 0)));
    drv3(0, 1'b0, 16'h0, 1'b0);
    #1;
    chk("t5_rdy_in2_again", 32'(s3.tready), 32'b100);
    tick();
    chk("t5_in2_again", 32'(m3.tdata), 32'(dat(2, 1, 0)));
    chk("t5_busy3", 32'(busy3), 32'd0);
    drv3(2, 1'b0, 16'h0, 1'b0);
    tick();
    chk("t5_drain", 32'(m3.tvalid), 32'd0);

    // Reset during beat 2 of a 4-beat packet from input 2 (rr_ptr is 2)
    drv4(2, 1'b1, dat(2, 2, 0), 1'b0);
    tick();
    chk("t6_b0", 32'(m4.tdata), 32'(dat(2, 2, 0)));
    drv4(2, 1'b1, dat(2, 2, 1), 1'b0);
    tick();
    chk("t6_b1", 32'(m4.tdata), 32'(dat(2, 2, 1)));
    chk("t6_busy_pre", 32'(busy4), 32'd1);
    drv4(2, 1'b1, dat(2, 2, 2), 1'b0);
    #1;
    aresetn = 1'b0;
    #1;
    chk("t6_rst_vld",  32'(m4.tvalid), 32'd0);
    chk("t6_rst_busy", 32'(busy4), 32'd0);
    chk("t6_rst_rdy",  32'(s4.tready), 32'b0000);
    drv4(1, 1'b1, dat(1, 3, 0), 1'b1);
    drv4(2, 1'b1, dat(2, 3, 0), 1'b1);
    drv4(3, 1'b1, dat(3, 3, 0), 1'b1);
    tick();
    chk("t6_held_vld", 32'(m4.tvalid), 32'd0);
    chk("t6_held_rdy", 32'(s4.tready), 32'b0000);
    aresetn = 1'b1;
    #1;
    chk("t6_post_rdy", 32'(s4.tready), 32'b0010);
    tick();
    chk("t6_post_data", 32'(m4.tdata), 32'(dat(1, 3, 0)));
    chk("t6_post_vld", 32'(m4.tvalid), 32'd1);
    for (int i = 0; i < 4; i++) drv4(i, 1'b0, 16'h0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
